// File: rtl/wb_regfile_sb.sv
// -----------------------------------------------------------------------------
// wb_regfile_sb
//   Write-back stage with integer register file and issue scoreboard.
//   - MEM->WB pipeline register with valid/allowin handshake and entry flush.
//   - XLEN x NREG register file, x0 hard-wired to zero, NRD combinational
//     read ports with optional bypass of the value committing this cycle.
//   - Per-register saturating pending-writer counters (SBW bits); issue
//     increments, commit decrements, sb_clear zeroes all, sticky overflow.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   mem_to_wb_valid/allowin  MEM->WB handshake; mem_flush kills the entering op
//   in_pc/wen/rd/wdata       incoming payload
//   wb_stall                 WB backpressure (ready_go = !wb_stall)
//   wb_valid/pc/rd/wen/wdata registered WB state; wb_commit = retire pulse
//   raddr/rdata/rbusy        packed read ports, port i at [i*W +: W]
//   sb_set/sb_rd/sb_clear    scoreboard reserve / flush
//   sb_ovf                   sticky: reserve attempted on a saturated counter
// -----------------------------------------------------------------------------
module wb_regfile_sb #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int SBW    = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_to_wb_valid,
  output logic                wb_allowin,
  input  logic                mem_flush,
  input  logic [31:0]         in_pc,
  input  logic                in_wen,
  input  logic [AW-1:0]       in_rd,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic                wb_stall,
  output logic                wb_valid,
  output logic [31:0]         wb_pc,
  output logic [AW-1:0]       wb_rd,
  output logic                wb_wen,
  output logic [XLEN-1:0]     wb_wdata,
  output logic                wb_commit,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_rd,
  input  logic                sb_clear,
  output logic                sb_ovf
);

  localparam logic [SBW-1:0] CNT_MAX = {SBW{1'b1}};
  localparam logic [SBW-1:0] CNT_ONE = SBW'(1);

  logic            ready_go;
  logic            rf_we;
  logic [XLEN-1:0] rf  [NREG];
  logic [SBW-1:0]  cnt [NREG];
  logic [NREG-1:0] inc_v;
  logic [NREG-1:0] dec_v;
  logic [AW-1:0]   ra  [NRD];
  logic            ovf_hit;

  assign ready_go   = !wb_stall;
  assign wb_allowin = !wb_valid || ready_go;
  assign wb_commit  = wb_valid && ready_go;
  assign rf_we      = wb_commit && wb_wen && (wb_rd != '0);

  // Pipeline register. Payload loads only when a real op arrives, so a bubble
  // leaves the previous payload in place.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_pc    <= '0;
      wb_rd    <= '0;
      wb_wen   <= 1'b0;
      wb_wdata <= '0;
    end else if (wb_allowin) begin
      wb_valid <= mem_to_wb_valid && !mem_flush;
      if (mem_to_wb_valid) begin
        wb_pc    <= in_pc;
        wb_rd    <= in_rd;
        wb_wen   <= in_wen;
        wb_wdata <= in_wdata;
      end
    end
  end

  // Register file. Entry 0 is never written, so it stays at its reset value.
  // NOTE: the array is reset because architectural state must read as zero
  // after reset; this forces a flop implementation rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else if (rf_we) begin
      rf[wb_rd] <= wb_wdata;
    end
  end

  // Per-register increment/decrement requests. Register 0 never tracks.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_v[r] = sb_set && (sb_rd == AW'(r));
      dec_v[r] = wb_commit && wb_wen && (wb_rd == AW'(r)) && (cnt[r] != '0);
    end
  end

  assign ovf_hit = inc_v[sb_rd] && !dec_v[sb_rd] && (cnt[sb_rd] == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_ovf <= 1'b0;
    end else begin
      if (ovf_hit) sb_ovf <= 1'b1;
      for (int r = 1; r < NREG; r++) begin
        if (sb_clear) begin
          cnt[r] <= '0;
        end else if (inc_v[r] && !dec_v[r] && cnt[r] != CNT_MAX) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec_v[r] && !inc_v[r]) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  // Read ports. A pending writer whose last outstanding write is committing
  // right now is not reported busy when the value is forwarded.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      ra[i] = raddr[i*AW +: AW];
      if (ra[i] == '0) begin
        rdata[i*XLEN +: XLEN] = '0;
      end else if (BYPASS != 0 && wb_commit && wb_wen && wb_rd == ra[i]) begin
        rdata[i*XLEN +: XLEN] = wb_wdata;
      end else begin
        rdata[i*XLEN +: XLEN] = rf[ra[i]];
      end
      rbusy[i] = (cnt[ra[i]] != '0) &&
                 !(BYPASS != 0 && dec_v[ra[i]] && !inc_v[ra[i]] && cnt[ra[i]] == CNT_ONE);
    end
  end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile_sb
//   Bench for wb_regfile_sb: a bypassing instance (checked every cycle against
//   an array-based reference model) and a non-bypassing instance sharing the
//   same stimulus. Directed table, randomized phase, reset-mid-stall sequence.
// -----------------------------------------------------------------------------
module tb_wb_regfile_sb;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int SMAX = 3;

  typedef struct {
    logic            mv, flush, wen;
    logic [31:0]     pc;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wdata;
    logic            stall;
    logic [AW-1:0]   ra0, ra1;
    logic            set;
    logic [AW-1:0]   srd;
    logic            clr;
  } in_t;

  typedef struct {
    in_t             i;
    logic            allow, commit;
    logic [XLEN-1:0] rd0, rd0_nb;
    logic            busy0, ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_to_wb_valid, mem_flush, in_wen, wb_stall, sb_set, sb_clear;
  logic [31:0] in_pc;
  logic [AW-1:0] in_rd, sb_rd;
  logic [XLEN-1:0] in_wdata;
  logic [2*AW-1:0] raddr;

  logic wb_allowin, wb_valid, wb_wen, wb_commit, sb_ovf;
  logic [31:0] wb_pc;
  logic [AW-1:0] wb_rd;
  logic [XLEN-1:0] wb_wdata;
  logic [2*XLEN-1:0] rdata;
  logic [1:0] rbusy;

  logic nb_allowin, nb_valid, nb_wen, nb_commit, nb_ovf;
  logic [31:0] nb_pc;
  logic [AW-1:0] nb_rd;
  logic [XLEN-1:0] nb_wdata;
  logic [2*XLEN-1:0] nb_rdata;
  logic [1:0] nb_rbusy;

  always #5 clk = ~clk;

  wb_regfile_sb #(.XLEN(64), .NREG(32), .NRD(2), .BYPASS(1), .SBW(2)) dut (
    .clk(clk), .rst(rst), .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin),
    .mem_flush(mem_flush), .in_pc(in_pc), .in_wen(in_wen), .in_rd(in_rd),
    .in_wdata(in_wdata), .wb_stall(wb_stall), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_wdata(wb_wdata), .wb_commit(wb_commit),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .sb_set(sb_set), .sb_rd(sb_rd),
    .sb_clear(sb_clear), .sb_ovf(sb_ovf)
  );

  wb_regfile_sb #(.XLEN(64), .NREG(32), .NRD(2), .BYPASS(0), .SBW(2)) dut_nb (
    .clk(clk), .rst(rst), .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(nb_allowin),
    .mem_flush(mem_flush), .in_pc(in_pc), .in_wen(in_wen), .in_rd(in_rd),
    .in_wdata(in_wdata), .wb_stall(wb_stall), .wb_valid(nb_valid), .wb_pc(nb_pc),
    .wb_rd(nb_rd), .wb_wen(nb_wen), .wb_wdata(nb_wdata), .wb_commit(nb_commit),
    .raddr(raddr), .rdata(nb_rdata), .rbusy(nb_rbusy), .sb_set(sb_set), .sb_rd(sb_rd),
    .sb_clear(sb_clear), .sb_ovf(nb_ovf)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state as plain arrays and integers.
  logic [XLEN-1:0] rf_m [32];
  int              cnt_m [32];
  bit              m_valid, m_wen, m_ovf;
  logic [AW-1:0]   m_rd;
  logic [31:0]     m_pc;
  logic [XLEN-1:0] m_wdata;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      rf_m[r]  = '0;
      cnt_m[r] = 0;
    end
    m_valid = 0; m_wen = 0; m_ovf = 0; m_rd = '0; m_pc = '0; m_wdata = '0;
  endtask

  function automatic logic [XLEN-1:0] exp_rdata(input in_t v, input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && m_valid && !v.stall && m_wen && m_rd == a) return m_wdata;
    return rf_m[a];
  endfunction

  function automatic logic exp_busy(input in_t v, input logic [AW-1:0] a);
    bit last_retiring;
    last_retiring = m_valid && !v.stall && m_wen && m_rd == a && cnt_m[a] == 1 &&
                    !(v.set && v.srd == a);
    return (cnt_m[a] != 0) && !last_retiring;
  endfunction

  task automatic model_update(input in_t v);
    bit commit, allow;
    int next_cnt;
    commit = m_valid && !v.stall;
    allow  = !m_valid || !v.stall;
    for (int r = 1; r < 32; r++) begin
      next_cnt = cnt_m[r] + ((v.set && v.srd == r) ? 1 : 0)
                          - ((commit && m_wen && m_rd == r && cnt_m[r] > 0) ? 1 : 0);
      if (next_cnt > SMAX) begin
        next_cnt = SMAX;
        m_ovf    = 1;
      end
      cnt_m[r] = v.clr ? 0 : next_cnt;
    end
    if (commit && m_wen && m_rd != 0) rf_m[m_rd] = m_wdata;
    if (allow) begin
      m_valid = v.mv && !v.flush;
      if (v.mv) begin
        m_pc = v.pc; m_rd = v.rd; m_wen = v.wen; m_wdata = v.wdata;
      end
    end
  endtask

  task automatic drive(input in_t v);
    mem_to_wb_valid = v.mv;
    mem_flush       = v.flush;
    in_pc           = v.pc;
    in_wen          = v.wen;
    in_rd           = v.rd;
    in_wdata        = v.wdata;
    wb_stall        = v.stall;
    raddr           = {v.ra1, v.ra0};
    sb_set          = v.set;
    sb_rd           = v.srd;
    sb_clear        = v.clr;
  endtask

  task automatic check_model(input in_t v);
    check("valid",  {63'd0, wb_valid},   {63'd0, m_valid});
    check("allow",  {63'd0, wb_allowin}, {63'd0, !m_valid || !v.stall});
    check("commit", {63'd0, wb_commit},  {63'd0, m_valid && !v.stall});
    check("pc",     {32'd0, wb_pc},      {32'd0, m_pc});
    check("rd",     {59'd0, wb_rd},      {59'd0, m_rd});
    check("wen",    {63'd0, wb_wen},     {63'd0, m_wen});
    check("wdata",  wb_wdata,            m_wdata);
    check("rdata0", rdata[XLEN-1:0],     exp_rdata(v, v.ra0, 1));
    check("rdata1", rdata[2*XLEN-1:XLEN], exp_rdata(v, v.ra1, 1));
    check("rbusy0", {63'd0, rbusy[0]},   {63'd0, exp_busy(v, v.ra0)});
    check("rbusy1", {63'd0, rbusy[1]},   {63'd0, exp_busy(v, v.ra1)});
    check("ovf",    {63'd0, sb_ovf},     {63'd0, m_ovf});
    check("nb_rdata0", nb_rdata[XLEN-1:0], exp_rdata(v, v.ra0, 0));
  endtask

  // One cycle: inputs applied just after negedge, outputs sampled 1ns later,
  // model advanced at the posedge.
  task automatic tick(input in_t v);
    drive(v);
    #1;
    check_model(v);
    @(posedge clk);
    model_update(v);
    @(negedge clk);
  endtask

  function automatic in_t mk(input bit mv, flush, wen, input int rd, input logic [XLEN-1:0] wdata,
                             input bit stall, input int ra0, input bit set, input int srd, input bit clr);
    in_t v;
    v.mv = mv; v.flush = flush; v.wen = wen; v.pc = 32'h1000_0000 + 32'(rd);
    v.rd = AW'(rd); v.wdata = wdata; v.stall = stall; v.ra0 = AW'(ra0); v.ra1 = '0;
    v.set = set; v.srd = AW'(srd); v.clr = clr;
    return v;
  endfunction

  function automatic vec_t row(input in_t i, input bit allow, commit, input logic [XLEN-1:0] rd0, rd0_nb,
                               input bit busy0, ovf);
    vec_t t;
    t.i = i; t.allow = allow; t.commit = commit; t.rd0 = rd0; t.rd0_nb = rd0_nb;
    t.busy0 = busy0; t.ovf = ovf;
    return t;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v.mv    = ($urandom_range(0, 2) != 0);
    v.flush = ($urandom_range(0, 7) == 0);
    v.wen   = ($urandom_range(0, 3) != 0);
    v.pc    = $urandom;
    v.rd    = AW'($urandom_range(0, 7));
    v.wdata = {$urandom, $urandom};
    v.stall = ($urandom_range(0, 2) == 0);
    v.ra0   = AW'($urandom_range(0, 7));
    v.ra1   = AW'($urandom_range(0, 7));
    v.set   = ($urandom_range(0, 2) == 0);
    v.srd   = AW'($urandom_range(0, 7));
    v.clr   = ($urandom_range(0, 19) == 0);
    return v;
  endfunction

  vec_t tbl [29];

  initial begin
    in_t idle;
    in_t v;
    idle = mk(0, 0, 0, 0, '0, 0, 0, 0, 0, 0);

    // Reset state.
    rst = 1'b1;
    drive(idle);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid",  {63'd0, wb_valid},   64'd0);
    check("rst_allow",  {63'd0, wb_allowin}, 64'd1);
    check("rst_commit", {63'd0, wb_commit},  64'd0);
    check("rst_ovf",    {63'd0, sb_ovf},     64'd0);
    check("rst_rdata",  rdata,               '0);
    check("rst_rbusy",  {62'd0, rbusy},      64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: bypass, x0, stall/flush, scoreboard corners.
    tbl[0]  = row(mk(0,0,0,0,64'h0,0,5,0,0,0),          1,0,64'h0,64'h0,0,0);
    tbl[1]  = row(mk(1,0,1,5,64'hDEADBEEF,0,5,0,0,0),   1,0,64'h0,64'h0,0,0);
    tbl[2]  = row(mk(0,0,0,0,64'h0,0,5,0,0,0),          1,1,64'hDEADBEEF,64'h0,0,0);
    tbl[3]  = row(mk(0,0,0,0,64'h0,0,5,0,0,0),          1,0,64'hDEADBEEF,64'hDEADBEEF,0,0);
    tbl[4]  = row(mk(1,0,1,0,64'h1234,0,0,0,0,0),       1,0,64'h0,64'h0,0,0);
    tbl[5]  = row(mk(0,0,0,0,64'h0,0,0,0,0,0),          1,1,64'h0,64'h0,0,0);
    tbl[6]  = row(mk(0,0,0,0,64'h0,0,0,0,0,0),          1,0,64'h0,64'h0,0,0);
    tbl[7]  = row(mk(1,0,1,9,64'h99,1,9,0,0,0),         1,0,64'h0,64'h0,0,0);
    tbl[8]  = row(mk(1,0,1,10,64'hAA,1,9,0,0,0),        0,0,64'h0,64'h0,0,0);
    tbl[9]  = row(mk(1,0,1,10,64'hAA,1,9,0,0,0),        0,0,64'h0,64'h0,0,0);
    tbl[10] = row(mk(1,0,1,10,64'hAA,1,9,0,0,0),        0,0,64'h0,64'h0,0,0);
    tbl[11] = row(mk(0,0,0,0,64'h0,0,9,0,0,0),          1,1,64'h99,64'h0,0,0);
    tbl[12] = row(mk(1,1,1,11,64'hBB,0,9,0,0,0),        1,0,64'h99,64'h99,0,0);
    tbl[13] = row(mk(0,0,0,0,64'h0,0,11,0,0,0),         1,0,64'h0,64'h0,0,0);
    tbl[14] = row(mk(0,0,0,0,64'h0,0,11,0,0,0),         1,0,64'h0,64'h0,0,0);
    tbl[15] = row(mk(0,0,0,0,64'h0,0,7,1,7,0),          1,0,64'h0,64'h0,0,0);
    tbl[16] = row(mk(0,0,0,0,64'h0,0,7,1,7,0),          1,0,64'h0,64'h0,1,0);
    tbl[17] = row(mk(1,0,1,7,64'h77,0,7,0,0,0),         1,0,64'h0,64'h0,1,0);
    tbl[18] = row(mk(0,0,0,0,64'h0,0,7,0,0,0),          1,1,64'h77,64'h0,1,0);
    tbl[19] = row(mk(1,0,1,7,64'h78,0,7,0,0,0),         1,0,64'h77,64'h77,1,0);
    tbl[20] = row(mk(0,0,0,0,64'h0,0,7,0,0,0),          1,1,64'h78,64'h77,0,0);
    tbl[21] = row(mk(0,0,0,0,64'h0,0,7,1,7,0),          1,0,64'h78,64'h78,0,0);
    tbl[22] = row(mk(1,0,1,7,64'h79,0,7,0,0,0),         1,0,64'h78,64'h78,1,0);
    tbl[23] = row(mk(0,0,0,0,64'h0,0,7,1,7,0),          1,1,64'h79,64'h78,1,0);
    tbl[24] = row(mk(0,0,0,0,64'h0,0,7,1,7,0),          1,0,64'h79,64'h79,1,0);
    tbl[25] = row(mk(0,0,0,0,64'h0,0,7,1,7,0),          1,0,64'h79,64'h79,1,0);
    tbl[26] = row(mk(0,0,0,0,64'h0,0,7,1,7,0),          1,0,64'h79,64'h79,1,0);
    tbl[27] = row(mk(0,0,0,0,64'h0,0,7,0,0,1),          1,0,64'h79,64'h79,1,1);
    tbl[28] = row(mk(0,0,0,0,64'h0,0,7,0,0,0),          1,0,64'h79,64'h79,0,1);

    for (int k = 0; k < 29; k++) begin
      drive(tbl[k].i);
      #1;
      check($sformatf("tbl%0d_allow", k),  {63'd0, wb_allowin}, {63'd0, tbl[k].allow});
      check($sformatf("tbl%0d_commit", k), {63'd0, wb_commit},  {63'd0, tbl[k].commit});
      check($sformatf("tbl%0d_rdata0", k), rdata[XLEN-1:0],     tbl[k].rd0);
      check($sformatf("tbl%0d_nb_rdata0", k), nb_rdata[XLEN-1:0], tbl[k].rd0_nb);
      check($sformatf("tbl%0d_rbusy0", k), {63'd0, rbusy[0]},   {63'd0, tbl[k].busy0});
      check($sformatf("tbl%0d_ovf", k),    {63'd0, sb_ovf},     {63'd0, tbl[k].ovf});
      #0;
      tick(tbl[k].i);
    end

    // Randomized phase against the model.
    for (int k = 0; k < 400; k++) begin
      v = rand_in();
      tick(v);
    end

    // Reset asserted while a stalled op with a pending write sits in WB.
    tick(idle);
    v = mk(1, 0, 1, 5, 64'hCAFE_F00D, 1, 5, 1, 5, 0);
    tick(v);
    v.mv = 0;
    drive(v);
    #1;
    check("stall_valid", {63'd0, wb_valid},   64'd1);
    check("stall_allow", {63'd0, wb_allowin}, 64'd0);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid",  {63'd0, wb_valid},   64'd0);
    check("midrst_allow",  {63'd0, wb_allowin}, 64'd1);
    check("midrst_commit", {63'd0, wb_commit},  64'd0);
    check("midrst_rdata",  rdata,               '0);
    check("midrst_nb_rdata", nb_rdata,          '0);
    check("midrst_rbusy",  {62'd0, rbusy},      64'd0);
    check("midrst_ovf",    {63'd0, sb_ovf},     64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(idle);
    v = mk(0, 0, 0, 0, '0, 0, 5, 0, 0, 0);
    v.ra1 = AW'(7);
    tick(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
